// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA 640x480 timing constants and vertical state encoding
package vga_timing_pkg;

  localparam int H_TOTAL = 1600;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 29;
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SCALE = 5;

  localparam logic [13:0] ROW_STRIDE = 14'h40;

  localparam int H_W   = 11;
  localparam int VL_W  = 9;
  localparam int REP_W = 3;

  localparam logic [1:0] VS_SYNC = 2'd0;
  localparam logic [1:0] VS_BP   = 2'd1;
  localparam logic [1:0] VS_DISP = 2'd2;
  localparam logic [1:0] VS_FP   = 2'd3;

  function automatic logic [1:0] vs_next(input logic [1:0] s);
    case (s)
      VS_SYNC: vs_next = VS_BP;
      VS_BP:   vs_next = VS_DISP;
      VS_DISP: vs_next = VS_FP;
      default: vs_next = VS_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/vga_line_counter.sv
// rtl/vga_line_counter.sv - horizontal period counter with end-of-line tick, shared with the horizontal unit
module vga_line_counter
  import vga_timing_pkg::*;
#(
  parameter int P_H_TOTAL = H_TOTAL
) (
  input  logic           clk_i,
  input  logic           resetn_i,
  input  logic           enable_i,
  output logic [H_W-1:0] hcount_o,
  output logic           line_tick_o
);

  logic [H_W-1:0] hcount_q, hcount_d;
  logic           last;

  assign last        = int'(hcount_q) == P_H_TOTAL - 1;
  assign line_tick_o = resetn_i && enable_i && last;
  assign hcount_o    = hcount_q;

  always_comb begin
    hcount_d = hcount_q;
    if (enable_i) hcount_d = last ? '0 : hcount_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) hcount_q <= '0;
    else           hcount_q <= hcount_d;
  end

endmodule

// File: rtl/vga_vsync_ctrl.sv
// rtl/vga_vsync_ctrl.sv - vertical sequencer: line FSM, v_sync/display window, VRAM row scaler
// Optional frame counter output under VGA_FRAME_COUNT_EN.
module vga_vsync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int P_H_TOTAL = H_TOTAL,
  parameter int P_V_SYNC  = V_SYNC,
  parameter int P_V_BP    = V_BP,
  parameter int P_V_DISP  = V_DISP,
  parameter int P_V_FP    = V_FP,
  parameter int P_V_SCALE = V_SCALE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        v_sync,
  output logic        h_sync_en,
  output logic        line_tick,
  output logic        frame_start,
  output logic [13:0] row_addr
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  logic [H_W-1:0]   hcount;
  logic [1:0]       state_q, state_d;
  logic [VL_W-1:0]  vline_q, vline_d;
  logic [6:0]       row_idx_q, row_idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [13:0]      row_addr_q, row_addr_d;
  logic             v_sync_q, h_sync_en_q;
  int               state_len;
  logic             state_end;

  vga_line_counter #(.P_H_TOTAL(P_H_TOTAL)) u_line (
    .clk_i       (clk),
    .resetn_i    (reset),
    .enable_i    (enable),
    .hcount_o    (hcount),
    .line_tick_o (line_tick)
  );

  always_comb begin
    case (state_q)
      VS_SYNC: state_len = P_V_SYNC;
      VS_BP:   state_len = P_V_BP;
      VS_DISP: state_len = P_V_DISP;
      default: state_len = P_V_FP;
    endcase
  end

  assign state_end = int'(vline_q) == state_len - 1;

  always_comb begin
    state_d    = state_q;
    vline_d    = vline_q;
    row_idx_d  = row_idx_q;
    rep_d      = rep_q;
    row_addr_d = row_addr_q;
    if (line_tick) begin
      if (state_end) begin
        state_d = vs_next(state_q);
        vline_d = '0;
      end else begin
        vline_d = vline_q + 1'b1;
      end
      // The last display line never advances the row: the front porch keeps showing the final row.
      if (state_q == VS_DISP && !state_end) begin
        if (int'(rep_q) == P_V_SCALE - 1) begin
          rep_d      = '0;
          row_idx_d  = row_idx_q + 1'b1;
          row_addr_d = row_addr_q + ROW_STRIDE;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      if (state_q == VS_FP && state_end) begin
        rep_d      = '0;
        row_idx_d  = '0;
        row_addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= VS_SYNC;
      vline_q     <= '0;
      row_idx_q   <= '0;
      rep_q       <= '0;
      row_addr_q  <= '0;
      v_sync_q    <= 1'b0;
      h_sync_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vline_q    <= vline_d;
      row_idx_q  <= row_idx_d;
      rep_q      <= rep_d;
      row_addr_q <= row_addr_d;
      if (enable) begin
        v_sync_q    <= state_q != VS_SYNC;
        h_sync_en_q <= state_q == VS_DISP;
      end
    end
  end

  assign frame_start = reset && enable && state_q == VS_SYNC && vline_q == '0 && hcount == '0;
  assign v_sync      = v_sync_q;
  assign h_sync_en   = h_sync_en_q;
  assign row_addr    = row_addr_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)           frame_cnt_q <= '0;
    else if (frame_start) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_vsync_ctrl.sv
// tb/tb_vga_vsync_ctrl.sv - scoreboard bench for vga_vsync_ctrl with a position-based timing model
module tb_vga_vsync_ctrl;

  localparam int H      = 16;
  localparam int VS     = 2;
  localparam int VB     = 3;
  localparam int VD     = 15;
  localparam int VF     = 2;
  localparam int SC     = 5;
  localparam int FRAME  = VS + VB + VD + VF;
  localparam int STRIDE = 'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        v_sync, h_sync_en, line_tick, frame_start;
  logic [13:0] row_addr;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]  frame_cnt;
`endif

  always #5 clk = ~clk;

  vga_vsync_ctrl #(
    .P_H_TOTAL (H),
    .P_V_SYNC  (VS),
    .P_V_BP    (VB),
    .P_V_DISP  (VD),
    .P_V_FP    (VF),
    .P_V_SCALE (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .v_sync      (v_sync),
    .h_sync_en   (h_sync_en),
    .line_tick   (line_tick),
    .frame_start (frame_start),
    .row_addr    (row_addr)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        lt;
    logic        fs;
    logic [13:0] row;
    logic [7:0]  fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   p     = 0;
  int   fsc   = 0;
  int   cyc   = 0;

  function automatic int line_of(input int pos);
    return (pos / H) % FRAME;
  endfunction

  function automatic int row_of(input int ln);
    if (ln < VS + VB)      return 0;
    if (ln < VS + VB + VD) return ((ln - VS - VB) / SC) * STRIDE;
    return (VD / SC - 1) * STRIDE;
  endfunction

  function automatic exp_t model(input int pos, input bit r, input bit e, input int fcount);
    exp_t x;
    int   h, ln, lp;
    h    = pos % H;
    ln   = line_of(pos);
    x.lt = r && e && (h == H - 1);
    x.fs = r && e && (h == 0) && (ln == 0);
    x.row = 14'(row_of(ln));
    if (pos == 0) begin
      x.vs = 1'b0;
      x.hs = 1'b0;
    end else begin
      lp   = line_of(pos - 1);
      x.vs = lp >= VS;
      x.hs = (lp >= VS + VB) && (lp < VS + VB + VD);
    end
    x.fc = 8'(fcount);
    return x;
  endfunction

  task automatic step(input bit r, input bit e);
    exp_t x;
    @(posedge clk);
    #1;
    reset  = r;
    enable = e;
    x = model(p, r, e, fsc);
    q.push_back(x);
    if (!r) begin
      p   = 0;
      fsc = 0;
    end else begin
      if (x.fs) fsc++;
      if (e) p++;
    end
  endtask

  task automatic advance_to(input int ln, input int h);
    int guard = 0;
    while (!(line_of(p) == ln && (p % H) == h) && guard < 2 * FRAME * H) begin
      step(1'b1, 1'b1);
      guard++;
    end
    n_cmp++;
    if (guard >= 2 * FRAME * H) begin
      n_bad++;
      $display("FAIL advance_to line=%0d h=%0d: position not reached, at p=%0d", ln, h, p);
    end
  endtask

  always @(negedge clk) begin
    exp_t x, a;
    if (q.size() > 0) begin
      x = q.pop_front();
      a.vs  = v_sync;
      a.hs  = h_sync_en;
      a.lt  = line_tick;
      a.fs  = frame_start;
      a.row = row_addr;
`ifdef VGA_FRAME_COUNT_EN
      a.fc  = frame_cnt;
`else
      a.fc  = x.fc;
`endif
      n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got vs=%b hs=%b lt=%b fs=%b row=%h fc=%0d expected vs=%b hs=%b lt=%b fs=%b row=%h fc=%0d",
                 cyc, a.vs, a.hs, a.lt, a.fs, a.row, a.fc, x.vs, x.hs, x.lt, x.fs, x.row, x.fc);
      end
      cyc++;
    end
  end

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    repeat (3) step(1'b0, 1'b1);

    repeat (2 * FRAME * H) step(1'b1, 1'b1);

    repeat (10 * FRAME * H) step(1'b1, $urandom_range(0, 9) != 0);

    // Stall mid-line inside the display window, then resume.
    advance_to(VS + VB + 4, H / 2);
    repeat (50) step(1'b1, 1'b0);
    repeat (3 * H) step(1'b1, 1'b1);

    // Reset in the middle of a display line.
    advance_to(VS + VB + 7, 10);
    step(1'b0, 1'b1);
    repeat (2 * FRAME * H) step(1'b1, 1'b1);

    // Reset and enable low together: reset wins.
    step(1'b0, 1'b0);
    repeat (FRAME * H) step(1'b1, 1'b1);

    repeat (6000) step($urandom_range(0, 499) != 0, $urandom_range(0, 7) != 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
